// File: rtl/dm_access_arbiter_pkg.sv
// Shared definitions for the data-memory access arbiter.
//   accSize_t   : access size codes as presented on {c,d}_size
//   arbState_t  : arbiter FSM states
//   portId_t    : requester identities (CPU data port, debug/loader port)
//   isIllegal() : misalignment / illegal-size / out-of-range classification
package dm_access_arbiter_pkg;

    localparam int DM_BYTES_DEF = 64;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } accSize_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_WRITE  = 2'b10,
        ST_RESP   = 2'b11
    } arbState_t;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } portId_t;

    // lastAddr is the highest byte address a full word may start at; every
    // access is checked against it regardless of size.
    function automatic logic isIllegal(input logic [1:0]  size,
                                       input logic [31:0] addr,
                                       input logic [31:0] lastAddr);
        logic bad;
        bad = (size == SZ_X)
            | ((size == SZ_H) & addr[0])
            | ((size == SZ_W) & (addr[1:0] != 2'b00))
            | (addr > lastAddr);
        return bad;
    endfunction

endpackage

// File: rtl/dm_access_arbiter_lane.sv
// Big-endian lane handling for the data-memory arbiter (combinational).
//   rbuf     in  32  word previously read from memory
//   wdata    in  32  store data, right-aligned
//   size     in  2   access size code
//   off      in  2   byte offset within the word
//   sext     in  1   sign-extend sub-word loads
//   merged   out 32  rbuf with the addressed lane(s) replaced by wdata
//   loadData out 32  addressed lane right-aligned, sign- or zero-extended
module dm_lane_unit
    import dm_access_arbiter_pkg::*;
(
    input  logic [31:0] rbuf,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        sext,
    output logic [31:0] merged,
    output logic [31:0] loadData
);

    // Big-endian: offset 0 is the most significant lane, so the bit
    // position of a byte lane is 8*(3-off), which is simply {~off, 3'b000}.
    logic [4:0]  byteLsb;
    logic [4:0]  halfLsb;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    assign byteLsb = {~off, 3'b000};
    assign halfLsb = {~off[1], 4'b0000};
    assign byteSel = rbuf[byteLsb +: 8];
    assign halfSel = rbuf[halfLsb +: 16];

    always_comb begin
        merged   = rbuf;
        loadData = rbuf;
        case (accSize_t'(size))
            SZ_B: begin
                merged[byteLsb +: 8] = wdata[7:0];
                loadData = {{24{sext & byteSel[7]}}, byteSel};
            end
            SZ_H: begin
                merged[halfLsb +: 16] = wdata[15:0];
                loadData = {{16{sext & halfSel[15]}}, halfSel};
            end
            SZ_W: begin
                merged   = wdata;
                loadData = rbuf;
            end
            default: begin
                merged   = rbuf;
                loadData = rbuf;
            end
        endcase
    end

endmodule

// File: rtl/dm_access_arbiter.sv
// Data-memory front end shared by the CPU data port (c_*) and the
// debug/loader port (d_*). Round-robin arbitration, byte/half/word loads
// with optional sign extension, sub-word stores as read-modify-write.
//   clk, rst_n          clock, async active-low reset
//   {c,d}_req/we/size/sext/addr/wdata   request and qualifiers, held to ack
//   {c,d}_ack           one-cycle completion pulse
//   rdata               load result during ack, otherwise 0
//   err                 with ack: misaligned, illegal size or out of range
//   mem_addr/wdata/rd/wr, mem_rdata     word-wide memory interface
//
// state     | meaning
// ST_IDLE   | wait for a request, pick a port, latch its qualifiers
// ST_ACCESS | word store, or read of the addressed word into rbuf
// ST_WRITE  | write back rbuf merged with sub-word store data
// ST_RESP   | ack the granted port, present rdata/err
module dm_access_arbiter
    import dm_access_arbiter_pkg::*;
#(
    parameter int DM_BYTES = DM_BYTES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [1:0]  c_size,
    input  logic        c_sext,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_sext,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] LAST_ADDR = 32'(DM_BYTES - 4);

    arbState_t   state, stateNext;
    portId_t     grant, last, pick;
    logic        anyReq;

    logic        selWe, selSext, selIllegal;
    logic [1:0]  selSize;
    logic [31:0] selAddr, selWdata;

    logic        reqWe, reqSext, reqErr;
    logic [1:0]  reqSize;
    logic [31:0] reqAddr, reqWdata, rbuf;

    logic [31:0] mergedWord, loadData;
    logic        isWordStore;

    // Contention goes to the port that was not served last.
    always_comb begin
        anyReq = c_req | d_req;
        if (c_req && d_req) begin
            pick = (last == PORT_C) ? PORT_D : PORT_C;
        end else if (c_req) begin
            pick = PORT_C;
        end else begin
            pick = PORT_D;
        end
    end

    assign selWe      = (pick == PORT_C) ? c_we    : d_we;
    assign selSize    = (pick == PORT_C) ? c_size  : d_size;
    assign selSext    = (pick == PORT_C) ? c_sext  : d_sext;
    assign selAddr    = (pick == PORT_C) ? c_addr  : d_addr;
    assign selWdata   = (pick == PORT_C) ? c_wdata : d_wdata;
    assign selIllegal = isIllegal(selSize, selAddr, LAST_ADDR);

    assign isWordStore = reqWe & (reqSize == SZ_W);

    dm_lane_unit u_lane (
        .rbuf     (rbuf),
        .wdata    (reqWdata),
        .size     (reqSize),
        .off      (reqAddr[1:0]),
        .sext     (reqSext),
        .merged   (mergedWord),
        .loadData (loadData)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            grant    <= PORT_C;
            last     <= PORT_D;
            reqWe    <= 1'b0;
            reqSize  <= 2'b00;
            reqSext  <= 1'b0;
            reqAddr  <= '0;
            reqWdata <= '0;
            reqErr   <= 1'b0;
            rbuf     <= '0;
        end else begin
            state <= stateNext;
            if (state == ST_IDLE && anyReq) begin
                grant    <= pick;
                reqWe    <= selWe;
                reqSize  <= selSize;
                reqSext  <= selSext;
                reqAddr  <= selAddr;
                reqWdata <= selWdata;
                reqErr   <= selIllegal;
            end
            if (state == ST_ACCESS && !isWordStore) begin
                rbuf <= mem_rdata;
            end
            if (state == ST_RESP) begin
                last <= grant;
            end
        end
    end

    // All outputs decode from registered state, so an async reset clears
    // mem_wr at once and no partial write can commit on the next negedge.
    always_comb begin
        stateNext = state;
        c_ack     = 1'b0;
        d_ack     = 1'b0;
        rdata     = '0;
        err       = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (anyReq) begin
                    stateNext = selIllegal ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_addr = {reqAddr[31:2], 2'b00};
                if (isWordStore) begin
                    mem_wr    = 1'b1;
                    mem_wdata = reqWdata;
                    stateNext = ST_RESP;
                end else begin
                    mem_rd    = 1'b1;
                    stateNext = reqWe ? ST_WRITE : ST_RESP;
                end
            end
            ST_WRITE: begin
                mem_addr  = {reqAddr[31:2], 2'b00};
                mem_wr    = 1'b1;
                mem_wdata = mergedWord;
                stateNext = ST_RESP;
            end
            ST_RESP: begin
                c_ack     = (grant == PORT_C);
                d_ack     = (grant == PORT_D);
                err       = reqErr;
                rdata     = (reqErr || reqWe) ? 32'h0 : loadData;
                stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dm_access_arbiter.sv
module tb_dm_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        c_req = 1'b0, c_we = 1'b0, c_sext = 1'b0;
    logic [1:0]  c_size = 2'b00;
    logic [31:0] c_addr = '0, c_wdata = '0;
    logic        c_ack;
    logic        d_req = 1'b0, d_we = 1'b0, d_sext = 1'b0;
    logic [1:0]  d_size = 2'b00;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        d_ack;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        err, mem_rd, mem_wr;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [64];
    logic [7:0] refMem [64];
    logic [5:0] wi;

    always #5 clk = ~clk;

    dm_access_arbiter #(.DM_BYTES(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_sext(c_sext),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_sext(d_sext),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .rdata(rdata), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    // Byte-addressed big-endian memory: combinational read, negedge write.
    assign wi = {mem_addr[5:2], 2'b00};
    assign mem_rdata = mem_rd ? {mem[wi], mem[wi + 6'd1], mem[wi + 6'd2], mem[wi + 6'd3]}
                              : 32'hzzzz_zzzz;

    always @(negedge clk) begin
        if (mem_wr) begin
            mem[wi]        <= mem_wdata[31:24];
            mem[wi + 6'd1] <= mem_wdata[23:16];
            mem[wi + 6'd2] <= mem_wdata[15:8];
            mem[wi + 6'd3] <= mem_wdata[7:0];
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] memWord(input int a);
        int b = a & 60;
        return {mem[b], mem[b + 1], mem[b + 2], mem[b + 3]};
    endfunction

    function automatic logic [31:0] refWord(input int a);
        int b = a & 60;
        return {refMem[b], refMem[b + 1], refMem[b + 2], refMem[b + 3]};
    endfunction

    function automatic bit modelIllegal(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 1'b1;
        if (addr > 32'd60) return 1'b1;
        if (size == 2'd1 && (addr % 2) != 0) return 1'b1;
        if (size == 2'd2 && (addr % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic sext, input logic [31:0] addr);
        int nb = 1 << size;
        logic [31:0] v = 32'h0;
        for (int i = 0; i < nb; i++) v = (v << 8) | 32'(refMem[int'(addr) + i]);
        if (sext && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        return v;
    endfunction

    task automatic modelStore(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        int nb = 1 << size;
        for (int i = 0; i < nb; i++) refMem[int'(addr) + i] = 8'(wdata >> (8 * (nb - 1 - i)));
    endtask

    // One access on a single port, started from IDLE; checks latency, err,
    // rdata, memory strobes and the resulting memory word.
    task automatic doAccess(input bit port, input logic we, input logic [1:0] size,
                            input logic sext, input logic [31:0] addr, input logic [31:0] wdata);
        bit illegal;
        logic [31:0] expData;
        int expLat, expRd, expWr, rdCnt, wrCnt, n;
        bit done, both, wrongAck, leak;
        illegal = modelIllegal(size, addr);
        expData = (!illegal && !we) ? modelLoad(size, sext, addr) : 32'h0;
        expLat  = illegal ? 1 : ((we && size != 2'd2) ? 3 : 2);
        expRd   = (!illegal && !(we && size == 2'd2)) ? 1 : 0;
        expWr   = (!illegal && we) ? 1 : 0;
        if (!port) begin
            c_we = we; c_size = size; c_sext = sext; c_addr = addr; c_wdata = wdata; c_req = 1'b1;
        end else begin
            d_we = we; d_size = size; d_sext = sext; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        end
        n = 0; done = 0; both = 0; wrongAck = 0; leak = 0; rdCnt = 0; wrCnt = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (mem_rd && mem_wr) both = 1;
            rdCnt += int'(mem_rd);
            wrCnt += int'(mem_wr);
            if (port ? c_ack : d_ack) wrongAck = 1;
            if (port ? d_ack : c_ack) begin
                done = 1;
                checkVal("latency", 32'(n), 32'(expLat));
                checkVal("err", {31'h0, err}, {31'h0, illegal});
                if (!we) checkVal("rdata", rdata, expData);
            end else if (rdata != 32'h0) begin
                leak = 1;
            end
        end
        c_req = 1'b0;
        d_req = 1'b0;
        checkVal("ack_seen", {31'h0, done}, 32'h1);
        @(posedge clk); #1;
        if (mem_rd && mem_wr) both = 1;
        rdCnt += int'(mem_rd);
        wrCnt += int'(mem_wr);
        checkVal("ack_pulse", {31'h0, c_ack | d_ack}, 32'h0);
        checkVal("rd_cycles", 32'(rdCnt), 32'(expRd));
        checkVal("wr_cycles", 32'(wrCnt), 32'(expWr));
        checkVal("rd_wr_excl", {31'h0, both}, 32'h0);
        checkVal("wrong_port_ack", {31'h0, wrongAck}, 32'h0);
        checkVal("rdata_idle", {31'h0, leak}, 32'h0);
        if (!illegal && we) modelStore(size, addr, wdata);
        checkVal("mem_word", memWord(int'(addr[5:0])), refWord(int'(addr[5:0])));
    endtask

    initial begin
        int cLeft, dLeft, overlap;
        int order[$];
        int bad;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'($urandom);
            refMem[i] = mem[i];
        end
        #2;
        checkVal("rst_acks", {30'h0, c_ack, d_ack}, 32'h0);
        checkVal("rst_err_strobes", {29'h0, err, mem_rd, mem_wr}, 32'h0);
        checkVal("rst_rdata", rdata, 32'h0);
        checkVal("rst_mem_addr", mem_addr, 32'h0);
        checkVal("rst_mem_wdata", mem_wdata, 32'h0);
        #10 rst_n = 1'b1;

        // word store then load
        doAccess(0, 1, 2'd2, 0, 32'd8, 32'hDEADBEEF);
        doAccess(0, 0, 2'd2, 0, 32'd8, 32'h0);
        checkVal("t1_word", memWord(8), 32'hDEADBEEF);

        // sub-word store as read-modify-write
        doAccess(0, 1, 2'd2, 0, 32'd0, 32'h11223344);
        doAccess(0, 1, 2'd0, 0, 32'd2, 32'h000000AA);
        checkVal("t2_word", memWord(0), 32'h1122AA44);

        // lane extraction and sign extension
        doAccess(0, 1, 2'd2, 0, 32'd4, 32'h80FF7F01);
        doAccess(0, 0, 2'd0, 1, 32'd5, 32'h0);
        doAccess(0, 0, 2'd0, 0, 32'd4, 32'h0);
        doAccess(0, 0, 2'd1, 1, 32'd6, 32'h0);
        doAccess(1, 0, 2'd1, 1, 32'd4, 32'h0);
        doAccess(1, 1, 2'd1, 0, 32'd6, 32'h0000BEEF);

        // illegal accesses
        doAccess(0, 0, 2'd2, 0, 32'd2, 32'h0);
        doAccess(0, 0, 2'd1, 0, 32'd61, 32'h0);
        doAccess(1, 1, 2'd3, 0, 32'd12, 32'h12345678);
        doAccess(0, 1, 2'd0, 0, 32'd62, 32'h55);

        // reset in the middle of a sub-word store's write cycle
        c_we = 1; c_size = 2'd0; c_sext = 0; c_addr = 32'd2; c_wdata = 32'h55; c_req = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkVal("t6_in_write", {31'h0, mem_wr}, 32'h1);
        rst_n = 1'b0;
        #1;
        checkVal("t6_rst_strobes", {30'h0, mem_wr, mem_rd}, 32'h0);
        checkVal("t6_rst_ack", {31'h0, c_ack}, 32'h0);
        checkVal("t6_rst_mem_addr", mem_addr, 32'h0);
        checkVal("t6_rst_mem_wdata", mem_wdata, 32'h0);
        c_req = 1'b0;
        @(negedge clk); #1;
        checkVal("t6_mem_unchanged", memWord(0), refWord(0));
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // simultaneous requests, each port renewing once
        c_we = 0; c_size = 2'd2; c_sext = 0; c_addr = 32'd8; c_req = 1;
        d_we = 0; d_size = 2'd2; d_sext = 0; d_addr = 32'd0; d_req = 1;
        cLeft = 2; dLeft = 2; overlap = 0;
        for (int cyc = 0; cyc < 40 && (cLeft > 0 || dLeft > 0); cyc++) begin
            @(posedge clk); #1;
            if (c_ack && d_ack) overlap++;
            if (c_ack) begin
                order.push_back(0);
                checkVal("arb_c_rdata", rdata, refWord(8));
                cLeft--;
                if (cLeft == 0) c_req = 1'b0;
            end
            if (d_ack) begin
                order.push_back(1);
                checkVal("arb_d_rdata", rdata, refWord(0));
                dLeft--;
                if (dLeft == 0) d_req = 1'b0;
            end
        end
        c_req = 1'b0; d_req = 1'b0;
        checkVal("arb_overlap", 32'(overlap), 32'h0);
        checkVal("arb_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < order.size() && i < 4; i++)
            checkVal("arb_order", 32'(order[i]), 32'(i % 2));
        @(posedge clk); #1;

        // randomized single-port traffic
        for (int k = 0; k < 200; k++) begin
            int r;
            logic [31:0] a;
            r = int'($urandom_range(0, 9));
            if (r == 0) a = $urandom;
            else if (r == 1) a = 32'($urandom_range(61, 70));
            else a = 32'($urandom_range(0, 63));
            doAccess(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), a, $urandom);
        end

        bad = 0;
        for (int i = 0; i < 64; i += 4) if (memWord(i) !== refWord(i)) bad++;
        checkVal("final_mem", 32'(bad), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
